// File: rtl/studio_keypad.sv
// studio_keypad: maps PS/2 make/break events onto up to four 10-key Studio II
// pads, latches the CPU key select and drives one active-low EF flag per pad.
// An optional per-pad stretcher keeps a fresh press visible for HOLD_CYCLES so
// that polling game code still sees very short taps.
//
// CPU select port: io_out is a single-cycle strobe with no back-pressure. A
// write is taken on any clk_sys edge where io_out=1 and io_n=SEL_PORT; the data
// is io_dout[3:0]. Select values 10..15 deliberately match no key.
module studio_keypad #(
  parameter int         NUM_PADS    = 2,
  parameter logic [2:0] SEL_PORT    = 3'd2,
  parameter int         HOLD_CYCLES = 0
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [10:0]            ps2_key,
  input  logic                   io_out,
  input  logic [2:0]             io_n,
  input  logic [7:0]             io_dout,
  output logic [NUM_PADS-1:0]    ef_n,
  output logic [10*NUM_PADS-1:0] keys_down,
  output logic [3:0]             key_sel
);

  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  // Scan code of every key, indexed [pad][key], key 0 first.
  localparam logic [0:3][0:9][7:0] KEY_MAP = '{
    '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46},
    '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D},
    '{8'h4D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44},
    '{8'h4C, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B}
  };

  logic                     prev_toggle;
  logic                     evt;
  logic [NUM_PADS-1:0]      ev_hit;
  logic [NUM_PADS-1:0][3:0] ev_key;
  logic [NUM_PADS-1:0]      sel_down;
  logic [NUM_PADS-1:0]      stretch_on;
  logic [3:0]               unused_dout;

  assign unused_dout = io_dout[7:4];

  // Track the PS/2 event toggle; reloading it in reset too means the first
  // cycle after reset never sees a phantom event.
  always_ff @(posedge clk_sys) begin
    prev_toggle <= ps2_key[10];
  end

  assign evt = (ps2_key[10] != prev_toggle) && !ps2_key[8];

  // Decode the scan code against every populated pad (at most one can hit).
  always_comb begin
    ev_hit = '0;
    ev_key = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int k = 0; k < 10; k++) begin
        if (ps2_key[7:0] == KEY_MAP[p][k]) begin
          ev_hit[p] = 1'b1;
          ev_key[p] = 4'(k);
        end
      end
    end
  end

  // Pressed bitmap: a matched event writes its key's bit with the make flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      keys_down <= '0;
    end else if (evt) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        for (int k = 0; k < 10; k++) begin
          if (ev_hit[p] && (ev_key[p] == 4'(k))) begin
            keys_down[10*p + k] <= ps2_key[9];
          end
        end
      end
    end
  end

  // Key select latch written by the CPU OUT instruction.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_sel <= 4'd0;
    end else if (io_out && (io_n == SEL_PORT)) begin
      key_sel <= io_dout[3:0];
    end
  end

  generate
    if (HOLD_CYCLES > 0) begin : g_stretch
      logic [NUM_PADS-1:0][CNT_W-1:0] cnt;
      logic [NUM_PADS-1:0][3:0]       held_key;

      // A make (re)arms its pad's window; otherwise count down and rest at 0.
      // Breaks are ignored so a tap stays visible for the full window.
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          cnt      <= '0;
          held_key <= '0;
        end else begin
          for (int p = 0; p < NUM_PADS; p++) begin
            if (evt && ps2_key[9] && ev_hit[p]) begin
              cnt[p]      <= CNT_W'(HOLD_CYCLES);
              held_key[p] <= ev_key[p];
            end else if (cnt[p] != '0) begin
              cnt[p] <= cnt[p] - CNT_W'(1);
            end
          end
        end
      end

      // held_key is always 0..9, so an invalid select can never match here.
      always_comb begin
        stretch_on = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
          stretch_on[p] = (cnt[p] != '0) && (held_key[p] == key_sel);
        end
      end
    end else begin : g_no_stretch
      assign stretch_on = '0;
    end
  endgenerate

  // Bitmap bit of the selected key on each pad; selects 10..15 give 0.
  always_comb begin
    sel_down = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int k = 0; k < 10; k++) begin
        if (key_sel == 4'(k)) begin
          sel_down[p] = keys_down[10*p + k];
        end
      end
    end
  end

  // Registered active-low "selected key held" flags.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ef_n <= '1;
    end else begin
      ef_n <= ~(sel_down | stretch_on);
    end
  end

endmodule
